// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// A word is accepted in any cycle where imem_req and imem_ack are both high.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-entry skid buffer and IF/ID register.
// The skid parks a word that was acked while decode stalled, so imem_req can drop.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master imem,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          if_id_valid,
    output logic [31:0]   if_id_ir,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_pc4,
    output logic          misalign_err
);

    typedef enum logic {S_REQ, S_HOLD} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } skid_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_inc;
    ifid_t       ifid, ifid_n;
    skid_t       skid, skid_n;
    logic        misalign_n;

    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            ifid         <= '{valid: 1'b0, ir: NOP_INSTR, pc: RESET_PC, pc4: RESET_PC + 32'd4};
            skid         <= '0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            ifid         <= ifid_n;
            skid         <= skid_n;
            misalign_err <= misalign_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ifid_n     = ifid;
        skid_n     = skid;
        misalign_n = misalign_err;
        if (redirect) begin
            // Flush wins over stall; any same-cycle ack is for the wrong path.
            pc_n         = {redirect_pc[31:2], 2'b00};
            ifid_n.valid = 1'b0;
            ifid_n.ir    = NOP_INSTR;
            skid_n       = '0;
            state_n      = S_REQ;
            if (redirect_pc[1:0] != 2'b00)
                misalign_n = 1'b1;
        end else begin
            case (state)
                S_REQ: begin
                    if (!stall) begin
                        if (imem.imem_ack) begin
                            ifid_n = '{valid: 1'b1, ir: imem.imem_rdata, pc: pc, pc4: pc_inc};
                            pc_n   = pc_inc;
                        end else begin
                            ifid_n.valid = 1'b0;
                            ifid_n.ir    = NOP_INSTR;
                        end
                    end else if (imem.imem_ack) begin
                        skid_n  = '{ir: imem.imem_rdata, pc: pc};
                        pc_n    = pc_inc;
                        state_n = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_n  = '{valid: 1'b1, ir: skid.ir, pc: skid.pc, pc4: skid.pc + 32'd4};
                        skid_n  = '0;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pc;
    assign if_id_valid    = ifid.valid;
    assign if_id_ir       = ifid.ir;
    assign if_id_pc       = ifid.pc;
    assign if_id_pc4      = ifid.pc4;

endmodule
